// File: rtl/elastic_offset_pipeline.sv
// elastic_offset_pipeline: a chain of NUM_STAGES elastic register slices.
// Each slice adds its own offset to the address, with wrap-around or
// saturating arithmetic, and carries the ID alongside the address.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   stage_offsets     per-stage offsets; stage k uses bits [k*AW +: AW]
//   sat_mode          0 = wrap-around add, 1 = saturating add
//   flush             synchronous drop of every in-flight entry
//   in_*              upstream valid/ready beat (address, id)
//   out_*             downstream valid/ready beat (address, id)
//   occupancy         number of valid stages (registered)
//   sat_event         sticky flag, set whenever a saturating add clamps

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module elastic_offset_pipeline #(
    parameter int ADDRESS_WIDTH = `ADDRESS_WIDTH,
    parameter int ID_WIDTH      = `ID_WIDTH,
    parameter int NUM_STAGES    = 4,
    parameter int CNT_WIDTH     = $clog2(NUM_STAGES + 1)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_STAGES*ADDRESS_WIDTH-1:0] stage_offsets,
    input  logic                                sat_mode,
    input  logic                                flush,
    input  logic [ADDRESS_WIDTH-1:0]            in_address,
    input  logic [ID_WIDTH-1:0]                 in_id,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [ADDRESS_WIDTH-1:0]            out_address,
    output logic [ID_WIDTH-1:0]                 out_id,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CNT_WIDTH-1:0]                occupancy,
    output logic                                sat_event
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int N  = NUM_STAGES;

    logic [N-1:0]         r_valid;
    logic [AW-1:0]        r_addr [N];
    logic [ID_WIDTH-1:0]  r_id   [N];
    logic [CNT_WIDTH-1:0] r_occ;
    logic                 r_sat;

    logic [N:0]           w_ready;
    logic [N-1:0]         w_upv;
    logic [AW-1:0]        w_upa  [N];
    logic [ID_WIDTH-1:0]  w_upi  [N];
    logic [AW:0]          w_sum  [N];
    logic [AW-1:0]        w_res  [N];
    logic [N-1:0]         w_load;
    logic [N-1:0]         w_clamp;
    logic [N-1:0]         w_vnext;
    logic [CNT_WIDTH-1:0] w_cnt;

    // Ready ripples from the output back to the input, so an empty
    // slice lets everything upstream of it advance (bubble collapse).
    always_comb begin
        w_ready = '0;
        w_ready[N] = out_ready;
        for (int k = N - 1; k >= 0; k--) begin
            w_ready[k] = !r_valid[k] || w_ready[k+1];
        end
    end

    always_comb begin
        w_upv = '0;
        w_upa = '{default: '0};
        w_upi = '{default: '0};
        w_upv[0] = in_valid;
        w_upa[0] = in_address;
        w_upi[0] = in_id;
        for (int k = 1; k < N; k++) begin
            w_upv[k] = r_valid[k-1];
            w_upa[k] = r_addr[k-1];
            w_upi[k] = r_id[k-1];
        end
    end

    always_comb begin
        w_sum   = '{default: '0};
        w_res   = '{default: '0};
        w_load  = '0;
        w_clamp = '0;
        w_vnext = '0;
        w_cnt   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum[k] = {1'b0, w_upa[k]}
                     + {1'b0, stage_offsets[k*AW +: AW]};
            w_clamp[k] = sat_mode && w_sum[k][AW];
            w_res[k] = w_clamp[k] ? {AW{1'b1}} : w_sum[k][AW-1:0];
            w_load[k] = w_ready[k] && w_upv[k] && !flush;
            // A ready slice takes whatever its upstream offers,
            // which also covers being drained in the same cycle.
            if (flush) begin
                w_vnext[k] = 1'b0;
            end else if (w_ready[k]) begin
                w_vnext[k] = w_upv[k];
            end else begin
                w_vnext[k] = r_valid[k];
            end
            w_cnt = w_cnt + CNT_WIDTH'(w_vnext[k]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_occ   <= '0;
            r_sat   <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_addr[k] <= '0;
                r_id[k]   <= '0;
            end
        end else begin
            r_valid <= w_vnext;
            r_occ   <= w_cnt;
            if (flush) begin
                r_sat <= 1'b0;
            end else if (|(w_load & w_clamp)) begin
                r_sat <= 1'b1;
            end
            for (int k = 0; k < N; k++) begin
                if (w_load[k]) begin
                    r_addr[k] <= w_res[k];
                    r_id[k]   <= w_upi[k];
                end
            end
        end
    end

    assign in_ready    = w_ready[0] && !flush;
    assign out_valid   = r_valid[N-1];
    assign out_address = r_addr[N-1];
    assign out_id      = r_id[N-1];
    assign occupancy   = r_occ;
    assign sat_event   = r_sat;

endmodule

// File: tb/tb_elastic_offset_pipeline.sv
// tb_elastic_offset_pipeline: directed bench for elastic_offset_pipeline.
// AW=8, ID=4, N=3, offsets {1,2,3}; expected values computed by hand.

module tb_elastic_offset_pipeline;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] stage_offsets;
    logic        sat_mode;
    logic        flush;
    logic [7:0]  in_address;
    logic [3:0]  in_id;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_address;
    logic [3:0]  out_id;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  occupancy;
    logic        sat_event;

    int vecs = 0;
    int errs = 0;

    elastic_offset_pipeline #(
        .ADDRESS_WIDTH(8),
        .ID_WIDTH(4),
        .NUM_STAGES(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .stage_offsets(stage_offsets),
        .sat_mode(sat_mode),
        .flush(flush),
        .in_address(in_address),
        .in_id(in_id),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_address(out_address),
        .out_id(out_id),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .occupancy(occupancy),
        .sat_event(sat_event)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL rst_ovalid got %b want 0", out_valid);
        end
        vecs++;
        if (occupancy !== 2'd0) begin
            errs++; $display("FAIL rst_occ got %0d want 0", occupancy);
        end
        vecs++;
        if (sat_event !== 1'b0) begin
            errs++; $display("FAIL rst_sat got %b want 0", sat_event);
        end
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++; $display("FAIL rst_iready got %b want 1", in_ready);
        end
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_latency();
        in_address = 8'h10; in_id = 4'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL lat_early got %b want 0", out_valid);
        end
        step();
        vecs++;
        if (out_valid !== 1'b1 || out_address !== 8'h16 || out_id !== 4'd5) begin
            errs++;
            $display("FAIL lat_out got v=%b a=%h id=%0d want v=1 a=16 id=5",
                     out_valid, out_address, out_id);
        end
        step();
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL lat_gone got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
            in_address = 8'h10 + 8'(i); in_id = 4'(i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = 8'h16 + 8'(i);
            vecs++;
            if (out_valid !== 1'b1 || out_address !== exp || out_id !== 4'(i)) begin
                errs++;
                $display("FAIL b2b_%0d got v=%b a=%h id=%0d want v=1 a=%h id=%0d",
                         i, out_valid, out_address, out_id, exp, i);
            end
            step();
        end
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL b2b_end got %b want 0", out_valid);
        end
    endtask

    task automatic test_wrap_sat();
        sat_mode = 1'b0;
        in_address = 8'hFE; in_id = 4'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        vecs++;
        if (out_valid !== 1'b1 || out_address !== 8'h04) begin
            errs++;
            $display("FAIL wrap_addr got v=%b a=%h want v=1 a=04",
                     out_valid, out_address);
        end
        vecs++;
        if (sat_event !== 1'b0) begin
            errs++; $display("FAIL wrap_sat got %b want 0", sat_event);
        end
        step();
        sat_mode = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        vecs++;
        if (out_valid !== 1'b1 || out_address !== 8'hFF) begin
            errs++;
            $display("FAIL sat_addr got v=%b a=%h want v=1 a=ff",
                     out_valid, out_address);
        end
        vecs++;
        if (sat_event !== 1'b1) begin
            errs++; $display("FAIL sat_flag got %b want 1", sat_event);
        end
        step();
        sat_mode = 1'b0;
    endtask

    task automatic test_flush();
        in_address = 8'hA0; in_id = 4'd1; in_valid = 1'b1;
        step();
        in_address = 8'hB0; in_id = 4'd2;
        step();
        vecs++;
        if (occupancy !== 2'd2) begin
            errs++; $display("FAIL fl_occ2 got %0d want 2", occupancy);
        end
        flush = 1'b1;
        in_address = 8'hC0; in_id = 4'd3;
        #1;
        vecs++;
        if (in_ready !== 1'b0) begin
            errs++; $display("FAIL fl_iready got %b want 0", in_ready);
        end
        step();
        flush = 1'b0; in_valid = 1'b0;
        vecs++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || sat_event !== 1'b0) begin
            errs++;
            $display("FAIL fl_clear got occ=%0d v=%b sat=%b want 0 0 0",
                     occupancy, out_valid, sat_event);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++;
            if (out_valid !== 1'b0) begin
                errs++; $display("FAIL fl_drop_%0d got %b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_stall();
        logic [4:0] exp_rdy;
        int idx;
        exp_rdy = 5'b00111;
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_address = 8'h20 + 8'(idx); in_id = 4'(idx); in_valid = 1'b1;
            #1;
            vecs++;
            if (in_ready !== exp_rdy[c]) begin
                errs++;
                $display("FAIL st_rdy_%0d got %b want %b", c, in_ready, exp_rdy[c]);
            end
            if (exp_rdy[c]) idx++;
            step();
        end
        vecs++;
        if (occupancy !== 2'd3 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL st_full got occ=%0d rdy=%b want 3 0", occupancy, in_ready);
        end
        in_valid = 1'b0;
        step();
        vecs++;
        if (out_valid !== 1'b1 || out_address !== 8'h26 || out_id !== 4'd0) begin
            errs++;
            $display("FAIL st_hold got v=%b a=%h id=%0d want v=1 a=26 id=0",
                     out_valid, out_address, out_id);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            step();
            vecs++;
            if (out_valid !== 1'b1 || out_address !== 8'h26 + 8'(i) || out_id !== 4'(i)) begin
                errs++;
                $display("FAIL st_drain_%0d got v=%b a=%h id=%0d want v=1 a=%h id=%0d",
                         i, out_valid, out_address, out_id, 8'h26 + 8'(i), i);
            end
        end
        step();
        vecs++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errs++;
            $display("FAIL st_empty got v=%b occ=%0d want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_address = 8'h30; in_id = 4'd9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        vecs++;
        if (out_valid !== 1'b1 || out_address !== 8'h36 || occupancy !== 2'd1
            || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL bub_one got v=%b a=%h occ=%0d rdy=%b want 1 36 1 1",
                     out_valid, out_address, occupancy, in_ready);
        end
        in_address = 8'h31; in_id = 4'd10; in_valid = 1'b1;
        step();
        in_address = 8'h32; in_id = 4'd11;
        step();
        in_valid = 1'b0;
        vecs++;
        if (occupancy !== 2'd3 || in_ready !== 1'b0 || out_address !== 8'h36) begin
            errs++;
            $display("FAIL bub_fill got occ=%0d rdy=%b a=%h want 3 0 36",
                     occupancy, in_ready, out_address);
        end
        out_ready = 1'b1;
        step();
        vecs++;
        if (out_valid !== 1'b1 || out_address !== 8'h37 || out_id !== 4'd10) begin
            errs++;
            $display("FAIL bub_d1 got v=%b a=%h id=%0d want 1 37 10",
                     out_valid, out_address, out_id);
        end
        step();
        vecs++;
        if (out_valid !== 1'b1 || out_address !== 8'h38 || out_id !== 4'd11) begin
            errs++;
            $display("FAIL bub_d2 got v=%b a=%h id=%0d want 1 38 11",
                     out_valid, out_address, out_id);
        end
        step();
    endtask

    task automatic test_async_reset();
        sat_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_address = 8'hFE - 8'(i); in_id = 4'(i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        vecs++;
        if (out_valid !== 1'b1 || occupancy !== 2'd3 || sat_event !== 1'b1) begin
            errs++;
            $display("FAIL ar_pre got v=%b occ=%0d sat=%b want 1 3 1",
                     out_valid, occupancy, sat_event);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vecs++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || sat_event !== 1'b0
            || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL ar_now got v=%b occ=%0d sat=%b rdy=%b want 0 0 0 1",
                     out_valid, occupancy, sat_event, in_ready);
        end
        step();
        reset_n = 1'b1;
        sat_mode = 1'b0;
        in_address = 8'h50; in_id = 4'd4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL ar_early got %b want 0", out_valid);
        end
        step();
        vecs++;
        if (out_valid !== 1'b1 || out_address !== 8'h56 || out_id !== 4'd4) begin
            errs++;
            $display("FAIL ar_lat got v=%b a=%h id=%0d want 1 56 4",
                     out_valid, out_address, out_id);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        stage_offsets = {8'd3, 8'd2, 8'd1};
        sat_mode = 1'b0;
        flush = 1'b0;
        in_address = '0;
        in_id = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_latency();
        test_back_to_back();
        test_wrap_sat();
        test_flush();
        test_stall();
        test_bubble();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
